// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit: PC, in-order imem requests, instruction FIFO, redirect flush
// Credit-based fetch: buffered plus outstanding never exceeds BUF_DEPTH, so responses always find a slot.
module inst_fetch #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    BUF_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_resp_valid,
   input  logic [DATA_WIDTH-1:0] imem_resp_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   output logic [6:0]            opcode,
   output logic [2:0]            funct3,
   output logic [6:0]            funct7
);
   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
   localparam logic [CNT_W:0]        DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

   typedef enum logic {FETCH, FLUSH} state_t;

   state_t                  state, state_next;
   logic [ADDR_WIDTH-1:0]   fetch_pc, resp_pc, target_pc;
   logic [CNT_W-1:0]        fifo_count, outstanding, discard, discard_next;
   logic [PTR_W-1:0]        rd_ptr, wr_ptr;
   logic [DATA_WIDTH-1:0]   buf_data [BUF_DEPTH];
   logic [ADDR_WIDTH-1:0]   buf_pc   [BUF_DEPTH];
   logic [CNT_W:0]          credit_used;
   logic                    req_allowed, req_fire, push, pop;
   logic [1:0]              unused_pc_bits;

   assign unused_pc_bits = redirect_pc[1:0];
   assign target_pc      = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
   assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   always_comb begin
      state_next   = state;
      discard_next = discard;
      req_allowed  = 1'b0;
      if (redirect_valid) begin
         // a response landing in the redirect cycle is already stale
         discard_next = outstanding - CNT_W'(imem_resp_valid);
         state_next   = (discard_next != '0) ? FLUSH : FETCH;
      end else begin
         if (state == FETCH) req_allowed = (credit_used < DEPTH_C);
         if (imem_resp_valid && discard != '0) discard_next = discard - CNT_W'(1);
         if (state == FLUSH && discard_next == '0) state_next = FETCH;
      end
   end

   // gate with reset so the request line drops the moment reset asserts
   assign imem_req_valid = req_allowed && !reset;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign push           = imem_resp_valid && !redirect_valid && (discard == '0);
   assign pop            = inst_valid && inst_ready && !redirect_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         fifo_count  <= '0;
         outstanding <= '0;
         discard     <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else if (redirect_valid) begin
         fetch_pc    <= target_pc;
         resp_pc     <= target_pc;
         fifo_count  <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         outstanding <= outstanding - CNT_W'(imem_resp_valid);
         discard     <= discard_next;
      end else begin
         if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
         outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
         discard     <= discard_next;
         if (push) begin
            wr_ptr  <= wr_ptr + PTR_W'(1);
            resp_pc <= resp_pc + PC_STEP;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_data[wr_ptr] <= imem_resp_data;
         buf_pc[wr_ptr]   <= resp_pc;
      end
   end

   // head values are forced to zero when empty so stale entries never leak out
   assign inst_valid = (fifo_count != '0);
   assign inst       = inst_valid ? buf_data[rd_ptr] : '0;
   assign inst_pc    = inst_valid ? buf_pc[rd_ptr]   : '0;
   assign opcode     = inst[6:0];
   assign funct3     = inst[14:12];
   assign funct7     = inst[31:25];

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - randomized bench for inst_fetch against a queue-based fetch model
// Model: memory queue tagged with a redirect epoch; FIFO of expected PCs; stale epochs are dropped.
module tb_inst_fetch;
   logic        clk, reset;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid, inst_ready;
   logic [31:0] inst, inst_pc;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;

   inst_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .opcode(opcode), .funct3(funct3), .funct7(funct7)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } req_t;

   req_t        mq[$];
   logic [31:0] fifo_q[$];
   logic [31:0] exp_req_pc;
   int          epoch, cyc;
   int          checks, errors;
   int          p_ready, p_resp, p_pop, p_redir, lat_min, lat_max;
   bit          force_redir, redir_on_resp, hit;
   logic [31:0] force_pc;
   int          first_req_cyc, first_valid_cyc, nreq;
   logic [31:0] first_req_addr, first_pc;
   logic [6:0]  first_op;
   bit          have_prev, wrap_seen;
   logic [31:0] prev_addr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0000_0033;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
   endfunction

   task automatic clear_cap();
      first_req_cyc   = -1;
      first_valid_cyc = -1;
      first_req_addr  = 32'hFFFF_FFFF;
      first_pc        = 32'hFFFF_FFFF;
      first_op        = 7'h7F;
      nreq            = 0;
   endtask

   task automatic step();
      bit          resp_v, stale, exp_rv, req_fire, popped;
      logic [31:0] w;
      req_t        e;
      imem_req_ready  = ($urandom_range(99) < p_ready);
      resp_v          = (mq.size() > 0) && (mq[0].due <= cyc) && ($urandom_range(99) < p_resp);
      imem_resp_valid = resp_v;
      imem_resp_data  = resp_v ? mem_word(mq[0].addr) : $urandom;
      inst_ready      = ($urandom_range(99) < p_pop);
      redirect_valid  = ($urandom_range(999) < p_redir);
      case ($urandom_range(3))
         0:       redirect_pc = $urandom;
         1:       redirect_pc = 32'hFFFF_FFF0 + $urandom_range(15);
         default: redirect_pc = $urandom_range(255);
      endcase
      if (force_redir) begin
         redirect_valid = 1'b1;
         redirect_pc    = force_pc;
         force_redir    = 1'b0;
      end
      if (redir_on_resp && resp_v && fifo_q.size() > 0) begin
         redirect_valid = 1'b1;
         inst_ready     = 1'b1;
         redirect_pc    = 32'h200;
         redir_on_resp  = 1'b0;
         hit            = 1'b1;
      end
      #1;
      stale = 1'b0;
      foreach (mq[i]) if (mq[i].epoch != epoch) stale = 1'b1;
      exp_rv = !redirect_valid && !stale && ((mq.size() + fifo_q.size()) < 2);
      check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_pc);
      check("inst_valid", {31'b0, inst_valid}, {31'b0, fifo_q.size() > 0});
      if (fifo_q.size() > 0) begin
         w = mem_word(fifo_q[0]);
         check("inst_pc", inst_pc, fifo_q[0]);
         check("inst", inst, w);
         check("opcode", {25'b0, opcode}, {25'b0, w[6:0]});
         check("funct3", {29'b0, funct3}, {29'b0, w[14:12]});
         check("funct7", {25'b0, funct7}, {25'b0, w[31:25]});
      end
      req_fire = imem_req_valid && imem_req_ready;
      popped   = inst_valid && inst_ready;
      if (req_fire) begin
         nreq++;
         if (first_req_cyc < 0) begin
            first_req_cyc  = cyc;
            first_req_addr = imem_req_addr;
         end
         if (have_prev && prev_addr == 32'hFFFF_FFFC) begin
            check("wrap_addr", imem_req_addr, 32'h0);
            wrap_seen = 1'b1;
         end
         prev_addr = imem_req_addr;
         have_prev = 1'b1;
      end
      if (inst_valid && first_valid_cyc < 0) begin
         first_valid_cyc = cyc;
         first_pc        = inst_pc;
         first_op        = opcode;
      end
      @(posedge clk);
      if (redirect_valid) begin
         epoch++;
         exp_req_pc = {redirect_pc[31:2], 2'b00};
         fifo_q.delete();
         have_prev = 1'b0;
         if (resp_v) void'(mq.pop_front());
      end else begin
         if (req_fire) begin
            e.addr  = imem_req_addr;
            e.epoch = epoch;
            e.due   = cyc + $urandom_range(lat_max, lat_min);
            mq.push_back(e);
            exp_req_pc = exp_req_pc + 32'd4;
         end
         if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
         if (resp_v) begin
            e = mq.pop_front();
            if (e.epoch == epoch) fifo_q.push_back(e.addr);
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'h0);
      check({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'h0);
      check({tag, "_inst"}, inst, 32'h0);
      check({tag, "_inst_pc"}, inst_pc, 32'h0);
      check({tag, "_fields"}, {15'b0, funct7, funct3, opcode}, 32'h0);
   endtask

   task automatic do_reset();
      redirect_valid  = 1'b0;
      imem_resp_valid = 1'b0;
      inst_ready      = 1'b0;
      imem_req_ready  = 1'b1;
      #2 reset = 1'b1;
      #1 check_outputs_zero("rst_async");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      mq.delete();
      fifo_q.delete();
      exp_req_pc    = 32'h0;
      epoch++;
      have_prev     = 1'b0;
      force_redir   = 1'b0;
      redir_on_resp = 1'b0;
   endtask

   task automatic set_mode(input int rdy, input int rsp, input int pp, input int rd, input int lmin, input int lmax);
      p_ready = rdy; p_resp = rsp; p_pop = pp; p_redir = rd; lat_min = lmin; lat_max = lmax;
   endtask

   initial begin
      checks = 0; errors = 0; epoch = 0; cyc = 0;
      exp_req_pc = 32'h0; have_prev = 0; wrap_seen = 0; hit = 0;
      force_redir = 0; redir_on_resp = 0; force_pc = 32'h0; prev_addr = 32'h0;
      reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
      clear_cap();
      @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b0;

      // first fetches from RESET_PC with a one-cycle memory, consumer stalled
      set_mode(100, 100, 0, 0, 1, 1);
      for (int i = 0; i < 8; i++) step();
      check("first_req_addr", first_req_addr, 32'h0);
      check("first_latency", 32'(first_valid_cyc - first_req_cyc), 32'd2);
      check("first_opcode", {25'b0, first_op}, 32'h33);
      check("first_inst_pc", first_pc, 32'h0);
      check("stall_req_count", 32'(nreq), 32'd2);

      // redirect with two requests still in flight
      do_reset();
      set_mode(100, 100, 0, 0, 6, 6);
      for (int i = 0; i < 2; i++) step();
      clear_cap();
      force_redir = 1'b1;
      force_pc    = 32'h103;
      step();
      set_mode(100, 100, 100, 0, 1, 1);
      for (int i = 0; i < 20; i++) step();
      check("redir_req_addr", first_req_addr, 32'h100);
      check("redir_inst_pc", first_pc, 32'h100);

      // redirect coinciding with a response and a pop
      do_reset();
      set_mode(100, 100, 0, 0, 2, 2);
      hit = 1'b0;
      redir_on_resp = 1'b1;
      for (int i = 0; i < 20 && !hit; i++) step();
      check("redir_resp_pop_hit", {31'b0, hit}, 32'h1);
      set_mode(100, 100, 100, 0, 1, 1);
      for (int i = 0; i < 10; i++) step();

      // address wrap at the top of the address space
      wrap_seen   = 1'b0;
      force_redir = 1'b1;
      force_pc    = 32'hFFFF_FFFC;
      for (int i = 0; i < 10; i++) step();
      check("wrap_seen", {31'b0, wrap_seen}, 32'h1);

      // random traffic, interrupted by a mid-burst reset
      for (int blk = 0; blk < 16; blk++) begin
         set_mode($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 0),
                  $urandom_range(40, 0), 1, $urandom_range(4, 1));
         for (int i = 0; i < 200; i++) step();
         if (blk == 7) begin
            do_reset();
            clear_cap();
            set_mode(100, 100, 100, 0, 1, 2);
            for (int i = 0; i < 5; i++) step();
            check("post_reset_addr", first_req_addr, 32'h0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
